helix_stream_arb: RTL and testbench

HELIX_STREAM_ARB -- requirements
Module: helix_stream_arb

---
 rtl/helix_pkg.sv | 21 ++
 rtl/helix_stream_fifo.sv | 75 +++++++
 rtl/helix_stream_arb.sv | 136 +++++++++++++
 tb/tb_helix_stream_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/helix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : helix_pkg
//  Description : Shared constants for the helix stream arbiter: arbitration
//                mode encodings and the channel-index width helper.
//  Contents    : ARB_RR, ARB_FIXED, ch_w()
//  Revision    : 1.0 - initial release
// ============================================================================
package helix_pkg;

  // Arbitration mode encodings
  localparam int ARB_RR    = 0;  // round-robin starting at rr_ptr
  localparam int ARB_FIXED = 1;  // channel 0 highest priority

  // Width of a channel index; never narrower than one bit
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/helix_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : helix_stream_fifo
//  Description : Per-channel synchronous FIFO with a first-word-fall-through
//                read port (rdata is the head whenever empty is low).
//  Ports       : clk, rst_n        - clock, async active-low reset
//                push, wdata       - write request (ignored when full)
//                pop               - read request (ignored when empty)
//                rdata             - current head entry
//                full, empty       - occupancy flags
//                level             - entries held, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module helix_stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: clearing the level makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/helix_stream_arb.sv
`default_nettype none
// ============================================================================
//  Module      : helix_stream_arb
//  Description : Merges NUM_CH valid/ready streams into one. Each channel is
//                buffered in its own FIFO; a round-robin or fixed-priority
//                arbiter moves one head word per cycle into a registered
//                output slot.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid/in_ready/in_data   - per-channel input streams
//                out_valid/out_ready/out_data- merged output stream
//                out_ch                      - source channel of out_data
//                fifo_level                  - per-channel FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module helix_stream_arb
  import helix_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CH-1:0]                     in_valid,
  output logic [NUM_CH-1:0]                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0]              in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic [ch_w(NUM_CH)-1:0]               out_ch,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   fifo_level
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int LW   = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] rdata [NUM_CH];

  logic              slot_free;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;

  // in_ready depends only on FIFO fullness, so there is no combinational
  // path from out_ready back to the sources.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign in_ready[c] = ~full[c];
      assign push[c]     = in_valid[c] & ~full[c];

      helix_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[c]),
        .wdata (in_data[c*DATA_W +: DATA_W]),
        .pop   (pop[c]),
        .rdata (rdata[c]),
        .full  (full[c]),
        .empty (empty[c]),
        .level (fifo_level[c*LW +: LW])
      );
    end
  endgenerate

  assign slot_free = ~out_valid_q | out_ready;

  // Scan channels in priority order; first non-empty channel wins.
  always_comb begin : p_arb
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == ARB_FIXED) cand = i;
      else                       cand = (int'(rr_ptr_q) + i) % NUM_CH;
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(cand);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (slot_free && grant_vld) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = rdata[grant_idx];
        out_ch_d   = grant_idx;
        if (ARB_MODE == ARB_RR) begin
          rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_helix_stream_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_helix_stream_arb
//  Description : Self-checking bench for helix_stream_arb. Two instances
//                (round-robin and fixed priority, 3 channels, depth 4) share
//                one stimulus; a queue-based reference model tracks both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_helix_stream_arb;
  import helix_pkg::*;

  localparam int NC  = 3;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int LW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC-1:0]     in_valid = '0;
  logic [NC*DW-1:0]  in_data = '0;
  logic              out_ready = 1'b0;

  logic              ov  [2];
  logic [NC-1:0]     ir  [2];
  logic [DW-1:0]     od  [2];
  logic [1:0]        och [2];
  logic [NC*LW-1:0]  lvl [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  helix_stream_arb #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ch(och[0]),
    .fifo_level(lvl[0]));

  helix_stream_arb #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ch(och[1]),
    .fifo_level(lvl[1]));

  // ---------------- reference model (index 0 = round-robin, 1 = fixed) ----
  logic [DW-1:0] mq [2][NC][$];
  logic          m_sv   [2];
  logic [DW-1:0] m_data [2];
  int            m_ch   [2];
  int            m_rr;
  int            m_len  [NC];
  int            m_g;
  int            m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) mq[d][c].delete();
        m_sv[d] = 1'b0; m_data[d] = '0; m_ch[d] = 0;
      end
      m_rr = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) m_len[c] = mq[d][c].size();
        if (!m_sv[d] || out_ready) begin
          m_g = -1;
          for (int i = 0; i < NC; i++) begin
            m_c = (d == 0) ? (m_rr + i) % NC : i;
            if (m_g < 0 && m_len[m_c] > 0) m_g = m_c;
          end
          if (m_g >= 0) begin
            m_sv[d]   = 1'b1;
            m_data[d] = mq[d][m_g].pop_front();
            m_ch[d]   = m_g;
            if (d == 0) m_rr = (m_g + 1) % NC;
          end else begin
            m_sv[d] = 1'b0;
          end
        end
        for (int c = 0; c < NC; c++)
          if (in_valid[c] && m_len[c] < DEP) mq[d][c].push_back(in_data[c*DW +: DW]);
      end
    end
  end

  // ---------------- helpers (stimulus / capture only) ----------------------
  logic [DW-1:0] got_d [2][$];
  int            got_c [2][$];

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Records every word presented while out_ready is held high; samples at the
  // current negedge first, then advances. Bounded by n cycles.
  task automatic collect(input int n);
    for (int d = 0; d < 2; d++) begin got_d[d].delete(); got_c[d].delete(); end
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 2; d++)
        if (ov[d]) begin got_d[d].push_back(od[d]); got_c[d].push_back(int'(och[d])); end
      @(negedge clk);
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b0) begin fails++; $display("FAIL reset_out_valid dut%0d got %0b exp 0", d, ov[d]); end
      tests++; if (od[d] !== '0) begin fails++; $display("FAIL reset_out_data dut%0d got %0h exp 0", d, od[d]); end
      tests++; if (och[d] !== '0) begin fails++; $display("FAIL reset_out_ch dut%0d got %0d exp 0", d, och[d]); end
      tests++; if (lvl[d] !== '0) begin fails++; $display("FAIL reset_levels dut%0d got %0h exp 0", d, lvl[d]); end
      tests++; if (ir[d] !== 3'b111) begin fails++; $display("FAIL reset_in_ready dut%0d got %b exp 111", d, ir[d]); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 3'b001; in_data[0 +: DW] = 32'd25;   // accepted at edge k
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b0) begin fails++; $display("FAIL lat_early_valid dut%0d got %0b exp 0", d, ov[d]); end
    end
    in_valid = 3'b010; in_data[DW +: DW] = 32'd50;
    @(negedge clk);
    in_valid = '0;
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b1 || od[d] !== 32'd25 || och[d] !== 2'd0) begin
        fails++; $display("FAIL lat_first dut%0d got v=%0b d=%0d ch=%0d exp v=1 d=25 ch=0", d, ov[d], od[d], och[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b1 || od[d] !== 32'd50 || och[d] !== 2'd1) begin
        fails++; $display("FAIL lat_second dut%0d got v=%0b d=%0d ch=%0d exp v=1 d=50 ch=1", d, ov[d], od[d], och[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b0) begin fails++; $display("FAIL lat_drain dut%0d got %0b exp 0", d, ov[d]); end
    end
  endtask

  task automatic test_arbitration();
    int exp_c, exp_d, seen [NC];
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 3'b111;
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = 32'(c*16 + k);
      @(negedge clk);
    end
    in_valid = '0; out_ready = 1'b1;
    collect(20);
    for (int d = 0; d < 2; d++) begin
      tests++; if (got_c[d].size() != 9) begin fails++; $display("FAIL arb_count dut%0d got %0d exp 9", d, got_c[d].size()); end
      for (int c = 0; c < NC; c++) seen[c] = 0;
      for (int i = 0; i < got_c[d].size() && i < 9; i++) begin
        exp_c = (d == 0) ? i % 3 : i / 3;
        exp_d = exp_c * 16 + seen[exp_c];
        seen[exp_c]++;
        tests++; if (got_c[d][i] != exp_c || got_d[d][i] !== 32'(exp_d)) begin
          fails++; $display("FAIL arb_seq dut%0d idx%0d got ch=%0d d=%0d exp ch=%0d d=%0d", d, i, got_c[d][i], got_d[d][i], exp_c, exp_d); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 3'b001; in_data[0 +: DW] = 32'(200 + k);
      @(negedge clk);
    end
    in_data[0 +: DW] = 32'd299;   // still offered, must be refused while full
    for (int d = 0; d < 2; d++) begin
      tests++; if (ir[d][0] !== 1'b0) begin fails++; $display("FAIL full_in_ready dut%0d got %0b exp 0", d, ir[d][0]); end
      tests++; if (lvl[d][0 +: LW] !== 3'd4) begin fails++; $display("FAIL full_level dut%0d got %0d exp 4", d, lvl[d][0 +: LW]); end
    end
    for (int t = 0; t < 10; t++) begin
      for (int d = 0; d < 2; d++) begin
        tests++; if (ov[d] !== 1'b1 || od[d] !== 32'd200 || och[d] !== 2'd0 || lvl[d][0 +: LW] !== 3'd4) begin
          fails++; $display("FAIL hold dut%0d cyc%0d got v=%0b d=%0d ch=%0d lvl=%0d exp v=1 d=200 ch=0 lvl=4", d, t, ov[d], od[d], och[d], lvl[d][0 +: LW]); end
      end
      @(negedge clk);
    end
    in_valid = '0; out_ready = 1'b1;
    collect(12);
    for (int d = 0; d < 2; d++) begin
      tests++; if (got_d[d].size() != 5) begin fails++; $display("FAIL drain_count dut%0d got %0d exp 5", d, got_d[d].size()); end
      for (int i = 0; i < got_d[d].size() && i < 5; i++) begin
        tests++; if (got_d[d][i] !== 32'(200 + i) || got_c[d][i] != 0) begin
          fails++; $display("FAIL drain_order dut%0d idx%0d got d=%0d ch=%0d exp d=%0d ch=0", d, i, got_d[d][i], got_c[d][i], 200 + i); end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 3'b001; in_data[0 +: DW] = 32'(300 + k);
      @(negedge clk);
    end
    in_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++; if (ov[d] !== 1'b0 || lvl[d] !== '0 || ir[d] !== 3'b111) begin
        fails++; $display("FAIL async_reset dut%0d got v=%0b lvl=%0h rdy=%b exp v=0 lvl=0 rdy=111", d, ov[d], lvl[d], ir[d]); end
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 3'b010; in_data[DW +: DW] = 32'd125;
    @(negedge clk);
    in_valid = '0;
    collect(8);
    for (int d = 0; d < 2; d++) begin
      tests++; if (got_d[d].size() != 1) begin fails++; $display("FAIL post_reset_count dut%0d got %0d exp 1", d, got_d[d].size()); end
      else begin
        tests++; if (got_d[d][0] !== 32'd125 || got_c[d][0] != 1) begin
          fails++; $display("FAIL post_reset_word dut%0d got d=%0d ch=%0d exp d=125 ch=1", d, got_d[d][0], got_c[d][0]); end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        tests++; if (ov[d] !== m_sv[d]) begin fails++; $display("FAIL rnd_valid dut%0d cyc%0d got %0b exp %0b", d, cyc, ov[d], m_sv[d]); end
        if (m_sv[d]) begin
          tests++; if (od[d] !== m_data[d] || int'(och[d]) != m_ch[d]) begin
            fails++; $display("FAIL rnd_data dut%0d cyc%0d got d=%0h ch=%0d exp d=%0h ch=%0d", d, cyc, od[d], och[d], m_data[d], m_ch[d]); end
        end
        for (int c = 0; c < NC; c++) begin
          tests++; if (int'(lvl[d][c*LW +: LW]) != mq[d][c].size() || ir[d][c] !== (mq[d][c].size() < DEP)) begin
            fails++; $display("FAIL rnd_fifo dut%0d cyc%0d ch%0d got lvl=%0d rdy=%0b exp lvl=%0d", d, cyc, c, lvl[d][c*LW +: LW], ir[d][c], mq[d][c].size()); end
        end
      end
      in_valid  = NC'($urandom);
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0) || (cyc > 550);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
